// File: rtl/tmds_lock_ctrl.sv
// tmds_lock_ctrl: TMDS 3-channel lock acquisition and loss monitor; `LOCK_STATS_EN` adds lost_count
module tmds_lock_ctrl #(
  parameter int RST_CYCLES     = 16,
  parameter int VLD_TIMEOUT    = 1048576,
  parameter int RDY_TIMEOUT    = 65536,
  parameter int VERIFY_TIMEOUT = 1048576,
  parameter int CTL_RUN        = 12,
  parameter int MISMATCH_MAX   = 4
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [2:0]  ch_vld,
  input  logic [2:0]  ch_rdy,
  input  logic [2:0]  ch_ctl_vld,
  input  logic [2:0]  ch_de,
  input  logic        force_relock,
  output logic        chan_reset,
  output logic        locked,
  output logic        lock_lost,
  output logic [7:0]  retry_cnt,
  output logic [2:0]  state,
  output logic [15:0] lost_count
);
  localparam int RW = $clog2(CTL_RUN + 1);
  localparam int MW = $clog2(MISMATCH_MAX + 1);
  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_VLD   = 3'd1,
    WAIT_RDY   = 3'd2,
    VERIFY     = 3'd3,
    LOCKED     = 3'd4
  } state_t;
  state_t cur, nxt;
  logic [23:0] timer;
  logic [RW-1:0] run, run_nxt;
  logic [MW-1:0] mm, mm_nxt;
  logic link_ok;
  assign state = cur;
  // next state: success beats timeout, force_relock beats everything outside RESET_HOLD
  always_comb begin
    link_ok = (&ch_vld) && (&ch_rdy);
    run_nxt = (ch_ctl_vld == 3'b111) ? run + 1'b1 : '0;
    mm_nxt = (ch_de != 3'b000 && ch_de != 3'b111) ? mm + 1'b1 : '0;
    nxt = cur;
    case (cur)
      RESET_HOLD: nxt = (timer == 24'(RST_CYCLES - 1)) ? WAIT_VLD : RESET_HOLD;
      WAIT_VLD:   nxt = (&ch_vld) ? WAIT_RDY : (timer == 24'(VLD_TIMEOUT - 1)) ? RESET_HOLD : WAIT_VLD;
      WAIT_RDY:   nxt = link_ok ? VERIFY : !(&ch_vld) ? RESET_HOLD :
                        (timer == 24'(RDY_TIMEOUT - 1)) ? RESET_HOLD : WAIT_RDY;
      VERIFY:     nxt = !link_ok ? RESET_HOLD : (run_nxt == RW'(CTL_RUN)) ? LOCKED :
                        (timer == 24'(VERIFY_TIMEOUT - 1)) ? RESET_HOLD : VERIFY;
      LOCKED:     nxt = (!link_ok || mm_nxt == MW'(MISMATCH_MAX)) ? RESET_HOLD : LOCKED;
      default:    nxt = RESET_HOLD;
    endcase
    if (force_relock && cur != RESET_HOLD) nxt = RESET_HOLD;
  end
  // state, timer, run/mismatch counters and registered outputs derived from the next state
  always_ff @(posedge pclk) begin
    if (reset) begin
      cur <= RESET_HOLD;
      timer <= '0;
      run <= '0;
      mm <= '0;
      chan_reset <= 1'b1;
      locked <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= '0;
    end else begin
      cur <= nxt;
      timer <= (nxt != cur) ? '0 : timer + 1'b1;
      run <= (cur == VERIFY && nxt == VERIFY) ? run_nxt : '0;
      mm <= (cur == LOCKED && nxt == LOCKED) ? mm_nxt : '0;
      chan_reset <= nxt == RESET_HOLD;
      locked <= nxt == LOCKED;
      lock_lost <= cur == LOCKED && nxt != LOCKED;
      if (nxt == RESET_HOLD && cur != RESET_HOLD && retry_cnt != 8'hff) retry_cnt <= retry_cnt + 1'b1;
    end
  end
`ifdef LOCK_STATS_EN
  // saturating count of LOCKED exits
  always_ff @(posedge pclk) begin
    if (reset) lost_count <= '0;
    else if (cur == LOCKED && nxt != LOCKED && lost_count != 16'hffff) lost_count <= lost_count + 1'b1;
  end
`else
  assign lost_count = '0;
`endif
endmodule

// File: tb/tb_tmds_lock_ctrl.sv
// tb_tmds_lock_ctrl: vector table, corner sequences and randomized run against a reference model
module tb_tmds_lock_ctrl;
  localparam int RST = 16, VLD_TO = 64, RDY_TO = 32, VER_TO = 64, CRUN = 12, MMAX = 4;
`ifdef LOCK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [2:0] A = 3'b111;
  logic pclk = 1'b0, reset = 1'b1, force_relock = 1'b0;
  logic [2:0] ch_vld = '0, ch_rdy = '0, ch_ctl_vld = '0, ch_de = '0;
  logic chan_reset, locked, lock_lost;
  logic [7:0] retry_cnt;
  logic [2:0] state;
  logic [15:0] lost_count;
  int errors = 0, checks = 0;

  tmds_lock_ctrl #(.RST_CYCLES(RST), .VLD_TIMEOUT(VLD_TO), .RDY_TIMEOUT(RDY_TO),
                   .VERIFY_TIMEOUT(VER_TO), .CTL_RUN(CRUN), .MISMATCH_MAX(MMAX)) dut (
    .pclk(pclk), .reset(reset), .ch_vld(ch_vld), .ch_rdy(ch_rdy), .ch_ctl_vld(ch_ctl_vld),
    .ch_de(ch_de), .force_relock(force_relock), .chan_reset(chan_reset), .locked(locked),
    .lock_lost(lock_lost), .retry_cnt(retry_cnt), .state(state), .lost_count(lost_count));

  always #5 pclk = ~pclk;

  typedef struct {
    logic [2:0] vld, rdy, ctl, de;
    logic frc;
    int n, st, cr, lk, ll, rc, lc;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic [2:0] v, logic [2:0] r, logic [2:0] c, logic [2:0] d, logic f,
                              int n, int st, int cr, int lk, int ll, int rc, int lc);
    vec_t e;
    e.vld = v; e.rdy = r; e.ctl = c; e.de = d; e.frc = f; e.n = n;
    e.st = st; e.cr = cr; e.lk = lk; e.ll = ll; e.rc = rc; e.lc = lc;
    tbl.push_back(e);
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int st, input int cr, input int lk,
                            input int ll, input int rc, input int lc);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".chan_reset"}, int'(chan_reset), cr);
    chk({tag, ".locked"}, int'(locked), lk);
    chk({tag, ".lock_lost"}, int'(lock_lost), ll);
    chk({tag, ".retry_cnt"}, int'(retry_cnt), rc);
    chk({tag, ".lost_count"}, int'(lost_count), STATS ? lc : 0);
  endtask

  // reference model: "age" is cycles spent in the current state
  int ms, mage, mrun, mmm, mrc, mlc, mcr, mlk, mll;
  function automatic void model_step();
    int n, run1, mm1;
    bit ok;
    if (reset) begin
      ms = 0; mage = 0; mrun = 0; mmm = 0; mrc = 0; mlc = 0; mcr = 1; mlk = 0; mll = 0;
      return;
    end
    ok = (ch_vld == 3'b111) && (ch_rdy == 3'b111);
    run1 = (ch_ctl_vld == 3'b111) ? mrun + 1 : 0;
    mm1 = (ch_de == 3'b000 || ch_de == 3'b111) ? 0 : mmm + 1;
    n = ms;
    if (force_relock && ms != 0) n = 0;
    else if (ms == 0) n = (mage == RST - 1) ? 1 : 0;
    else if (ms == 1) begin
      if (ch_vld == 3'b111) n = 2;
      else if (mage == VLD_TO - 1) n = 0;
    end else if (ms == 2) begin
      if (ok) n = 3;
      else if (ch_vld != 3'b111 || mage == RDY_TO - 1) n = 0;
    end else if (ms == 3) begin
      if (!ok) n = 0;
      else if (run1 == CRUN) n = 4;
      else if (mage == VER_TO - 1) n = 0;
    end else if (ms == 4) begin
      if (!ok || mm1 == MMAX) n = 0;
    end else n = 0;
    if (n == 0 && ms != 0 && mrc < 255) mrc++;
    mll = (ms == 4 && n != 4) ? 1 : 0;
    if (mll == 1 && mlc < 65535) mlc++;
    mrun = (ms == 3 && n == 3) ? run1 : 0;
    mmm = (ms == 4 && n == 4) ? mm1 : 0;
    mage = (n != ms) ? 0 : mage + 1;
    ms = n;
    mcr = (n == 0) ? 1 : 0;
    mlk = (n == 4) ? 1 : 0;
  endfunction

  initial begin
    tick();
    tick();
    check_outs("reset", 0, 1, 0, 0, 0, 0);
    reset = 1'b0;
    // vld rdy ctl de frc n | st cr lk ll rc lc
    add(0, 0, 0, 0, 0, 15, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 63, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 16, 1, 0, 0, 0, 1, 0);
    add(A, 0, 0, 0, 0, 1,  2, 0, 0, 0, 1, 0);
    add(A, A, 0, 0, 0, 1,  3, 0, 0, 0, 1, 0);
    add(A, A, A, 0, 0, 10, 3, 0, 0, 0, 1, 0);
    add(A, A, 0, 0, 0, 1,  3, 0, 0, 0, 1, 0);
    add(A, A, A, 0, 0, 11, 3, 0, 0, 0, 1, 0);
    add(A, A, A, 0, 0, 1,  4, 0, 1, 0, 1, 0);
    add(A, A, A, 5, 0, 3,  4, 0, 1, 0, 1, 0);
    add(A, A, A, 7, 0, 1,  4, 0, 1, 0, 1, 0);
    add(A, A, A, 5, 0, 3,  4, 0, 1, 0, 1, 0);
    add(A, A, A, 5, 0, 1,  0, 1, 0, 1, 2, 1);
    add(A, A, A, 7, 0, 1,  0, 1, 0, 0, 2, 1);
    add(A, A, A, 7, 0, 14, 0, 1, 0, 0, 2, 1);
    add(A, A, A, 7, 0, 1,  1, 0, 0, 0, 2, 1);
    add(A, A, A, 7, 0, 1,  2, 0, 0, 0, 2, 1);
    add(A, A, A, 7, 0, 1,  3, 0, 0, 0, 2, 1);
    add(A, A, A, 7, 0, 11, 3, 0, 0, 0, 2, 1);
    add(A, A, A, 7, 0, 1,  4, 0, 1, 0, 2, 1);
    add(A, 5, A, 7, 0, 1,  0, 1, 0, 1, 3, 2);
    add(A, A, A, 7, 0, 1,  0, 1, 0, 0, 3, 2);
    add(A, A, A, 7, 1, 1,  0, 1, 0, 0, 3, 2);
    add(A, A, A, 7, 0, 13, 0, 1, 0, 0, 3, 2);
    add(A, A, A, 7, 0, 1,  1, 0, 0, 0, 3, 2);
    add(A, A, A, 7, 1, 1,  0, 1, 0, 0, 4, 2);
    foreach (tbl[i]) begin
      ch_vld = tbl[i].vld; ch_rdy = tbl[i].rdy; ch_ctl_vld = tbl[i].ctl;
      ch_de = tbl[i].de; force_relock = tbl[i].frc;
      repeat (tbl[i].n) tick();
      check_outs($sformatf("row%0d", i), tbl[i].st, tbl[i].cr, tbl[i].lk, tbl[i].ll, tbl[i].rc, tbl[i].lc);
    end
    force_relock = 1'b0;
    ch_ctl_vld = 3'b000;
    repeat (18) tick();
    chk("verify_before_reset.state", int'(state), 3);
    reset = 1'b1;
    tick();
    check_outs("reset_in_verify", 0, 1, 0, 0, 0, 0);
    reset = 1'b0;
    ch_vld = '0; ch_rdy = '0; ch_ctl_vld = '0; ch_de = '0;
    repeat (80 * 100) tick();
    chk("retry_100", int'(retry_cnt), 100);
    repeat (80 * 200) tick();
    chk("retry_sat", int'(retry_cnt), 255);
    chk("retry_sat.state", int'(state), 0);
    reset = 1'b1;
    model_step();
    tick();
    check_outs("rand_reset", ms, mcr, mlk, mll, mrc, mlc);
    for (int c = 0; c < 4000; c++) begin
      ch_vld = ($urandom_range(0, 99) < 3) ? 3'($urandom) : A;
      ch_rdy = ($urandom_range(0, 99) < 3) ? 3'($urandom) : A;
      ch_ctl_vld = ($urandom_range(0, 99) < 10) ? 3'($urandom) : A;
      ch_de = ($urandom_range(0, 99) < 8) ? 3'($urandom) : ($urandom_range(0, 1) == 1 ? A : 3'b000);
      force_relock = $urandom_range(0, 299) == 0;
      reset = $urandom_range(0, 1999) == 0;
      model_step();
      tick();
      check_outs($sformatf("rand%0d", c), ms, mcr, mlk, mll, mrc, mlc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tmds_lock_ctrl.md
Name: tmds_lock_ctrl

Overview:
- Sequences lock acquisition for the three TMDS decoder channels of one HDMI receive port.
- Holds the decoders in reset, then waits for phase alignment (per-channel vld) and channel bonding (per-channel rdy).
- Confirms lock with a run of simultaneous control tokens, then monitors for loss of lock and re-sequences with a reset-and-retry when lock drops.
- Sits between the three decoder instances and the downstream video/HDCP logic.

Parameters:
- RST_CYCLES, 16: decoder reset hold length in pclk cycles (min 2).
- VLD_TIMEOUT, 1048576: max cycles in WAIT_VLD.
- RDY_TIMEOUT, 65536: max cycles in WAIT_RDY.
- VERIFY_TIMEOUT, 1048576: max cycles in VERIFY.
- CTL_RUN, 12: consecutive all-channel control-token cycles required to declare lock.
- MISMATCH_MAX, 4: consecutive cycles of de disagreement that force a relock.

Ports:
- pclk  input  1  pixel clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- ch_vld  input  3  per-channel phase-aligned flag (iamvld of ch0..ch2).
- ch_rdy  input  3  per-channel bonded flag (iamrdy of ch0..ch2).
- ch_ctl_vld  input  3  per-channel control-token-decoded flag.
- ch_de  input  3  per-channel decoded de.
- force_relock  input  1  single-cycle request to restart acquisition.
- chan_reset  output  1  reset to all three decoders.
- locked  output  1  link locked.
- lock_lost  output  1  one-cycle pulse when leaving LOCKED.
- retry_cnt  output  8  saturating count of relock attempts.
- state  output  3  current state encoding.
- lost_count  output  16  lock-loss event count (see Optional Feature).

Behaviour:
- Single clock domain. All outputs are registered.
- Reset is synchronous, active-high; it sets state=RESET_HOLD(0), timer=0, chan_reset=1, locked=0, lock_lost=0, retry_cnt=0, lost_count=0, run and mismatch counters=0.
- State encodings: RESET_HOLD=0, WAIT_VLD=1, WAIT_RDY=2, VERIFY=3, LOCKED=4. Codes 5-7 are illegal and go to RESET_HOLD next cycle.
- Timer: 24-bit, cleared on every state entry, increments each cycle while in a state.
- RESET_HOLD: chan_reset=1. When timer==RST_CYCLES-1, go to WAIT_VLD. chan_reset is therefore high for exactly RST_CYCLES cycles after reset is released.
- WAIT_VLD: when ch_vld==3'b111, go to WAIT_RDY. Else when timer==VLD_TIMEOUT-1, go to RESET_HOLD (retry).
- WAIT_RDY: when ch_vld and ch_rdy are both 3'b111, go to VERIFY. If any ch_vld bit drops, go to RESET_HOLD (retry). Else on timer==RDY_TIMEOUT-1, go to RESET_HOLD (retry).
- VERIFY:
  - If any ch_vld or ch_rdy bit drops, go to RESET_HOLD (retry).
  - run counter increments when ch_ctl_vld==3'b111 and clears otherwise.
  - When run reaches CTL_RUN, go to LOCKED.
  - Else on timer==VERIFY_TIMEOUT-1, go to RESET_HOLD (retry).
- LOCKED: locked=1.
  - If any ch_vld or ch_rdy bit drops, go to RESET_HOLD.
  - mismatch counter increments while ch_de is neither 000 nor 111 and clears otherwise. Reaching MISMATCH_MAX goes to RESET_HOLD.
  - No timeout in LOCKED.
- Exiting LOCKED to any state: lock_lost=1 for one cycle, locked=0 in the same cycle.
- Success condition beats timeout in the same cycle.
- force_relock in any state other than RESET_HOLD goes to RESET_HOLD. It overrides every other transition. It is ignored in RESET_HOLD: the timer is not restarted and retry_cnt is not incremented.
- retry_cnt: +1 on every entry into RESET_HOLD except from reset; saturates at 255.
- reset asserted mid-sequence always wins and returns to initial values.

Optional Feature:
- Macro LOCK_STATS_EN.
- Defined: lost_count increments on every LOCKED exit and saturates at 65535.
- Undefined: lost_count is constant 0 and no counter logic is built.
- All other behaviour is identical either way.

Test Plan:
- Release reset with all inputs 0 -> chan_reset high for 16 cycles, then state=1. With RST_CYCLES=16, VLD_TIMEOUT=64: state returns to 0 at cycle 64 of WAIT_VLD and retry_cnt=1.
- Raise ch_vld=111, then ch_rdy=111, then hold ch_ctl_vld=111 for 12 cycles -> state 1->2->3->4 and locked=1 on the 13th cycle after VERIFY entry. With ch_ctl_vld broken at cycle 11, the count restarts and lock needs 12 more.
- In LOCKED, drop ch_rdy[1] for one cycle -> lock_lost pulse, locked=0, state=0, retry_cnt+1, lost_count=1 (LOCK_STATS_EN).
- In LOCKED, hold ch_de=3'b101 for 3 cycles then 111 -> stays locked. Hold 101 for 4 cycles -> relock sequence starts.
- force_relock and ch_vld==111 in the same cycle in WAIT_VLD -> state=0. force_relock pulsed during RESET_HOLD -> hold length unchanged, retry_cnt unchanged.
- Force 300 timeouts -> retry_cnt saturates at 255. Assert reset in VERIFY -> all outputs return to reset values next cycle.
